// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D memory port arbiter: FSM encodings, owner IDs
// and parameter range checks.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    function automatic bit latency_ok(input int unsigned v);
        return (v >= 1) && (v <= 15);
    endfunction

    function automatic bit starve_limit_ok(input int unsigned v);
        return (v >= 1) && (v <= 15);
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between fetch (I) and load/store (D); D has priority unless
// I has been passed over STARVE_LIMIT times in a row.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic i_req,
    input  logic d_req,
    output logic win_i,
    output logic win_d
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        win_i = 1'b0;
        win_d = 1'b0;
        if (arb_en) begin
            if (d_req && !(i_req && (starve_cnt_q == LIMIT))) begin
                win_d = 1'b1;
            end else if (i_req) begin
                win_i = 1'b1;
            end
        end

        starve_cnt_d = starve_cnt_q;
        if (!i_req || win_i) begin
            starve_cnt_d = '0;
        end else if (win_d && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU fetch and load/store traffic onto one single-ported memory,
// one access outstanding, with registered grant/response pulses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic [DW-1:0]   mem_rdata
);

    if (!latency_ok(MEM_LATENCY)) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be 1..15");
    end
    if (!starve_limit_ok(STARVE_LIMIT)) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
    end

    localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);

    logic [1:0]      state_q, state_d;
    logic [3:0]      lat_cnt_q, lat_cnt_d;
    logic            owner_q, owner_d;
    logic            cmd_we_q, cmd_we_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW/8-1:0] mem_wstrb_q, mem_wstrb_d;
    logic            i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
    logic            i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [DW-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic            arb_en, win_i, win_d;

    assign arb_en = (state_q == ST_IDLE) || (state_q == ST_RESP);

    mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk    (clk),
        .rst    (rst),
        .arb_en (arb_en),
        .i_req  (i_req),
        .d_req  (d_req),
        .win_i  (win_i),
        .win_d  (win_d)
    );

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        owner_d     = owner_q;
        cmd_we_d    = cmd_we_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_wstrb_d = '0;
        i_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        i_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                // The winner's command is loaded straight into the memory-side
                // registers so it appears on mem_* during the ISSUE cycle.
                if (win_d) begin
                    state_d     = ST_ISSUE;
                    owner_d     = OWNER_D;
                    cmd_we_d    = d_we;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_we ? d_wdata : '0;
                    mem_wstrb_d = d_we ? d_wstrb : '0;
                    d_gnt_d     = 1'b1;
                end else if (win_i) begin
                    state_d    = ST_ISSUE;
                    owner_d    = OWNER_I;
                    cmd_we_d   = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = i_addr;
                    i_gnt_d    = 1'b1;
                end
            end
            ST_ISSUE: begin
                lat_cnt_d = LAT_INIT;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt_q == '0) begin
                    state_d = ST_RESP;
                    if (owner_q == OWNER_D) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = cmd_we_q ? '0 : mem_rdata;
                    end else begin
                        i_rvalid_d = 1'b1;
                        i_rdata_d  = mem_rdata;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            owner_q     <= OWNER_I;
            cmd_we_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            i_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            owner_q     <= owner_d;
            cmd_we_q    <= cmd_we_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            i_gnt_q     <= i_gnt_d;
            d_gnt_q     <= d_gnt_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign i_gnt     = i_gnt_q;
    assign i_rvalid  = i_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed 2-cycle-latency memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int viol         = 0;
    int n_igt = 0, n_dgt = 0, n_irv = 0, n_drv = 0, n_mreq = 0;

    mem_port_arbiter #(
        .AW(32), .DW(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data for a read seen at edge e is presented two cycles later.
    logic [31:0] mem [0:255];
    logic [31:0] stage;
    always @(posedge clk) begin
        logic [31:0] rd;
        logic [31:0] wv;
        rd = 32'hA5A5_A5A5;
        if (mem_req) begin
            rd = mem_we ? 32'hFFFF_FFFF : mem[mem_addr[9:2]];
            if (mem_we) begin
                wv = mem[mem_addr[9:2]];
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) wv[b*8 +: 8] = mem_wdata[b*8 +: 8];
                mem[mem_addr[9:2]] <= wv;
            end
        end
        stage     <= rd;
        mem_rdata <= stage;
    end

    always @(negedge clk) begin
        if (i_gnt && d_gnt) viol++;
        if (i_rvalid && d_rvalid) viol++;
        if ((i_gnt && i_rvalid) || (d_gnt && d_rvalid)) viol++;
        if (i_gnt) n_igt++;
        if (d_gnt) n_dgt++;
        if (i_rvalid) n_irv++;
        if (d_rvalid) n_drv++;
        if (mem_req) n_mreq++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // which: 0 i_gnt, 1 d_gnt, 2 i_rvalid, 3 d_rvalid, other = any gnt
    task automatic wait_pulse(input string tag, input int which, input int budget, output int at);
        logic hit;
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            case (which)
                0:       hit = i_gnt;
                1:       hit = d_gnt;
                2:       hit = i_rvalid;
                3:       hit = d_rvalid;
                default: hit = i_gnt | d_gnt;
            endcase
            if (hit) begin
                at = cyc;
                break;
            end
        end
        check({tag, "_seen"}, 64'(at >= 0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, at, m1, snap;
        logic [9:0] order;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h40] = 32'h0050_0093;  // byte 0x100
        mem[8'h10] = 32'h1111_1111;  // byte 0x040

        // 1: reset with both requests asserted
        rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 32'h100; d_addr = 32'h40; d_wdata = '0; d_wstrb = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ctrl", {58'd0, i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we}, 64'd0);
            check("rst_data", 64'(|{i_rdata, d_rdata, mem_addr, mem_wdata, mem_wstrb}), 64'd0);
        end
        rst = 1'b0;
        wait_pulse("first_gnt", 4, 6, at);
        check("first_gnt_is_d", {62'd0, d_gnt, i_gnt}, 64'd2);
        i_req = 1'b0; d_req = 1'b0;
        wait_pulse("t1_drv", 3, 6, at);
        check("t1_drdata", 64'(d_rdata), 64'h1111_1111);
        snap = n_igt;
        repeat (8) @(negedge clk);
        check("dropped_i_not_served", 64'(n_igt), 64'(snap));

        // 2: lone fetch latency and data
        i_addr = 32'h100; i_req = 1'b1; c0 = cyc;
        wait_pulse("t2_gnt", 0, 6, at);
        check("t2_gnt_cycle", 64'(at - c0), 64'd1);
        check("t2_mem_addr", 64'(mem_addr), 64'h100);
        check("t2_mem_we_strb", {59'd0, mem_we, mem_wstrb}, 64'd0);
        i_req = 1'b0;
        wait_pulse("t2_rv", 2, 6, at);
        check("t2_rv_cycle", 64'(at - c0), 64'd4);
        check("t2_irdata", 64'(i_rdata), 64'h0050_0093);
        repeat (2) @(negedge clk);

        // 3: partial store then back-to-back load of the same word
        d_addr = 32'h200; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011; d_req = 1'b1;
        wait_pulse("t3_st_gnt", 1, 6, m1);
        check("t3_st_cmd", {27'd0, mem_we, mem_wstrb, mem_wdata}, {27'd0, 1'b1, 4'b0011, 32'hDEAD_BEEF});
        d_we = 1'b0; d_wdata = '0; d_wstrb = '0;
        wait_pulse("t3_st_rv", 3, 6, at);
        check("t3_st_rdata", 64'(d_rdata), 64'd0);
        wait_pulse("t3_ld_gnt", 1, 6, at);
        check("t3_b2b_spacing", 64'(at - m1), 64'd4);
        check("t3_ld_cmd", {27'd0, mem_we, mem_wstrb, mem_wdata}, 64'd0);
        check("t3_ld_addr", 64'(mem_addr), 64'h200);
        d_req = 1'b0;
        wait_pulse("t3_ld_rv", 3, 6, at);
        check("t3_ld_rdata", 64'(d_rdata), 64'h0000_BEEF);
        repeat (2) @(negedge clk);

        // 4: both requesters saturating -> D,D,D,D,I,D,D,D,D,I (1 = D)
        order = 10'b11110_11110;
        d_addr = 32'h40; i_addr = 32'h100; i_req = 1'b1; d_req = 1'b1;
        for (int g = 0; g < 10; g++) begin
            wait_pulse("t4_gnt", 4, 6, at);
            check("t4_order", {63'd0, d_gnt}, {63'd0, order[9 - g]});
        end
        i_req = 1'b0; d_req = 1'b0;
        wait_pulse("t4_last_rv", 2, 6, at);
        check("t4_irdata", 64'(i_rdata), 64'h0050_0093);
        repeat (2) @(negedge clk);

        // 5: reset during WAIT of a load abandons it
        d_addr = 32'h40; d_we = 1'b0; d_req = 1'b1;
        wait_pulse("t5_gnt", 1, 6, at);
        d_req = 1'b0;
        @(negedge clk);
        snap = n_drv;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_no_drv", 64'(n_drv), 64'(snap));
        check("t5_drdata_cleared", 64'(d_rdata), 64'd0);
        i_addr = 32'h100; i_req = 1'b1; c0 = cyc;
        wait_pulse("t5_igt", 0, 6, at);
        i_req = 1'b0;
        wait_pulse("t5_irv", 2, 6, at);
        check("t5_rv_cycle", 64'(at - c0), 64'd4);
        check("t5_irdata", 64'(i_rdata), 64'h0050_0093);
        repeat (4) @(negedge clk);

        // 6: global invariants
        check("onehot_viol", 64'(viol), 64'd0);
        check("mem_req_vs_gnt", 64'(n_mreq), 64'(n_igt + n_dgt));
        check("rvalid_total", 64'(n_irv + n_drv), 64'(n_igt + n_dgt - 1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
